// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Generates VGA raster timing for the display path. A clock divider produces a
//   one-clk pixelTick every PIX_DIV clks. The hCount/vCount raster counters advance
//   on each tick. hSync, vSync, bright and frameStart are derived from the next-state
//   counter values and registered alongside them, so every output is coherent with
//   the hCount/vCount that is visible on the same cycle.
// Ports
//   clk         in   1   system clock
//   rst_n       in   1   asynchronous, active-low reset
//   pixelTick   out  1   one-clk pulse per pixel; the counters advance on it
//   hCount      out  10  horizontal pixel index, 0..H_TOTAL-1
//   vCount      out  10  line index, 0..V_TOTAL-1
//   hSync       out  1   active-low, 0 while hCount < H_SYNC
//   vSync       out  1   active-low, 0 while vCount < V_SYNC
//   bright      out  1   1 inside the visible window
//   frameStart  out  1   one-clk pulse when the raster wraps to (0,0)
module vga_timing_gen #(
   parameter int unsigned PIX_DIV  = 4,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_TOTAL  = 800,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_TOTAL  = 525
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic       pixelTick,
   output logic [9:0] hCount,
   output logic [9:0] vCount,
   output logic       hSync,
   output logic       vSync,
   output logic       bright,
   output logic       frameStart
);

   localparam logic [2:0] DIV_LAST = 3'(PIX_DIV - 1);
   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_SYNC_W = 10'(H_SYNC);
   localparam logic [9:0] V_SYNC_W = 10'(V_SYNC);
   localparam logic [9:0] H_VIS_LO = 10'(H_SYNC + H_BP);
   localparam logic [9:0] H_VIS_HI = 10'(H_SYNC + H_BP + H_ACTIVE);
   localparam logic [9:0] V_VIS_LO = 10'(V_SYNC + V_BP);
   localparam logic [9:0] V_VIS_HI = 10'(V_SYNC + V_BP + V_ACTIVE);

   logic [2:0] divCount;
   logic [2:0] divNext;
   logic       tickNext;
   logic [9:0] hNext;
   logic [9:0] vNext;
   logic       frameWrap;

   // The tick is registered on the same edge that advances the counters, so the
   // cycle with pixelTick=1 already shows the new hCount/vCount.
   always_comb begin
      tickNext  = (divCount == DIV_LAST);
      divNext   = tickNext ? '0 : divCount + 3'd1;
      hNext     = hCount;
      vNext     = vCount;
      frameWrap = 1'b0;
      if (tickNext) begin
         if (hCount == H_LAST) begin
            hNext = '0;
            if (vCount == V_LAST) begin
               vNext     = '0;
               frameWrap = 1'b1;
            end else begin
               vNext = vCount + 10'd1;
            end
         end else begin
            hNext = hCount + 10'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         divCount   <= '0;
         pixelTick  <= 1'b0;
         hCount     <= '0;
         vCount     <= '0;
         hSync      <= 1'b0;
         vSync      <= 1'b0;
         bright     <= 1'b0;
         frameStart <= 1'b0;
      end else begin
         divCount   <= divNext;
         pixelTick  <= tickNext;
         hCount     <= hNext;
         vCount     <= vNext;
         hSync      <= (hNext >= H_SYNC_W);
         vSync      <= (vNext >= V_SYNC_W);
         bright     <= (hNext >= H_VIS_LO) && (hNext < H_VIS_HI) &&
                       (vNext >= V_VIS_LO) && (vNext < V_VIS_HI);
         frameStart <= frameWrap;
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

   // Small raster so whole frames fit in a short run; A uses PIX_DIV=4, B uses PIX_DIV=1.
   localparam int S_HS = 8, S_HBP = 6, S_HA = 20, S_HT = 40;
   localparam int S_VS = 2, S_VBP = 3, S_VA = 10, S_VT = 20;
   localparam int FRAME_A = S_HT * S_VT * 4;
   localparam int FRAME_B = S_HT * S_VT * 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic       ptA, hsA, vsA, brA, fsA;
   logic [9:0] hA, vA;
   logic       ptB, hsB, vsB, brB, fsB;
   logic [9:0] hB, vB;
   logic       ptD, hsD, vsD, brD, fsD;
   logic [9:0] hD, vD;

   vga_timing_gen #(.PIX_DIV(4), .H_SYNC(S_HS), .H_BP(S_HBP), .H_ACTIVE(S_HA), .H_TOTAL(S_HT),
                    .V_SYNC(S_VS), .V_BP(S_VBP), .V_ACTIVE(S_VA), .V_TOTAL(S_VT)) dutA (
      .clk(clk), .rst_n(rst_n), .pixelTick(ptA), .hCount(hA), .vCount(vA),
      .hSync(hsA), .vSync(vsA), .bright(brA), .frameStart(fsA));

   vga_timing_gen #(.PIX_DIV(1), .H_SYNC(S_HS), .H_BP(S_HBP), .H_ACTIVE(S_HA), .H_TOTAL(S_HT),
                    .V_SYNC(S_VS), .V_BP(S_VBP), .V_ACTIVE(S_VA), .V_TOTAL(S_VT)) dutB (
      .clk(clk), .rst_n(rst_n), .pixelTick(ptB), .hCount(hB), .vCount(vB),
      .hSync(hsB), .vSync(vsB), .bright(brB), .frameStart(fsB));

   vga_timing_gen dutD (
      .clk(clk), .rst_n(rst_n), .pixelTick(ptD), .hCount(hD), .vCount(vD),
      .hSync(hsD), .vSync(vsD), .bright(brD), .frameStart(fsD));

   int checks = 0;
   int errors = 0;
   int n = 0;          // posedges since the last reset release
   int lastFsA = -1;
   int lastFsB = -1;
   int fsCountA = 0;

   // Expected outputs after n clk edges, from pixel arithmetic:
   // ticks so far = n/p, raster position = ticks modulo the line/frame size.
   function automatic logic [24:0] model(int p, int hs, int hbp, int ha, int ht,
                                         int vs, int vbp, int va, int vt, int cyc);
      int   ticks, h, v;
      logic pt, fs, br;
      ticks = cyc / p;
      h     = ticks % ht;
      v     = (ticks / ht) % vt;
      pt    = (cyc > 0) && (cyc % p == 0);
      fs    = pt && (ticks % (ht * vt) == 0);
      br    = (h >= hs + hbp) && (h < hs + hbp + ha) && (v >= vs + vbp) && (v < vs + vbp + va);
      return {pt, 10'(h), 10'(v), logic'(h >= hs), logic'(v >= vs), br, fs};
   endfunction

   task automatic chk(input string tag, input logic [24:0] obs, input logic [24:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s at n=%0d observed=%h expected=%h", tag, n, obs, exp);
      end
   endtask

   task automatic checkAll();
      chk("rasterA", {ptA, hA, vA, hsA, vsA, brA, fsA},
          model(4, S_HS, S_HBP, S_HA, S_HT, S_VS, S_VBP, S_VA, S_VT, n));
      chk("rasterB", {ptB, hB, vB, hsB, vsB, brB, fsB},
          model(1, S_HS, S_HBP, S_HA, S_HT, S_VS, S_VBP, S_VA, S_VT, n));
      chk("rasterD", {ptD, hD, vD, hsD, vsD, brD, fsD},
          model(4, 96, 48, 640, 800, 2, 33, 480, 525, n));
   endtask

   task automatic checkResetVals(input string tag);
      chk({tag, "_A"}, {ptA, hA, vA, hsA, vsA, brA, fsA}, '0);
      chk({tag, "_B"}, {ptB, hB, vB, hsB, vsB, brB, fsB}, '0);
      chk({tag, "_D"}, {ptD, hD, vD, hsD, vsD, brD, fsD}, '0);
   endtask

   // Advance k clocks, checking every DUT against the model on each falling edge.
   task automatic step(input int k);
      for (int i = 0; i < k; i++) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         checkAll();
         if (fsA === 1'b1) begin
            fsCountA++;
            if (lastFsA >= 0) chk("periodA", 25'(n - lastFsA), 25'(FRAME_A));
            lastFsA = n;
         end
         if (fsB === 1'b1) begin
            if (lastFsB >= 0) chk("periodB", 25'(n - lastFsB), 25'(FRAME_B));
            lastFsB = n;
         end
      end
   endtask

   // Assert reset between edges, confirm immediate effect, hold, release on a falling edge.
   task automatic asyncReset();
      #($urandom_range(1, 3));
      rst_n = 1'b0;
      #1;
      checkResetVals("asyncRst");
      repeat (2) @(negedge clk);
      checkResetVals("rstHold");
      rst_n   = 1'b1;
      n       = 0;
      lastFsA = -1;
      lastFsB = -1;
   endtask

   initial begin
      // Power-up reset.
      repeat (3) @(negedge clk);
      checkResetVals("porRst");
      rst_n = 1'b1;
      n     = 0;

      // First pixel tick of the default-parameter instance arrives on clk 4.
      step(3);
      chk("firstTickPending", {24'd0, ptD}, 25'd0);
      step(1);
      chk("firstTick", {4'd0, ptD, hD, vD}, {4'd0, 1'b1, 10'd1, 10'd0});

      // Two full frames of A (covers a full default line and the 799->0 wrap too).
      step(2 * FRAME_A + 10);
      chk("frameCountA", 25'(fsCountA), 25'd2);

      // Random run lengths, each ended by an asynchronous reset at a random point.
      for (int r = 0; r < 5; r++) begin
         step(int'($urandom_range(20, 3500)));
         asyncReset();
      end
      step(int'($urandom_range(100, 900)));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
